// File: rtl/video_dnn_frame_vote.sv
// Frame-level class vote accumulator: counts weighted per-pixel class votes over one frame,
// then scans the counters and emits the winning class and its count as a single-beat result.
module video_dnn_frame_vote #(
  parameter int unsigned NUM_CLASS     = 11,
  parameter int unsigned IGNORE_CLASS  = 10,
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned TNUMBER_WIDTH = 4,
  parameter int unsigned TCOUNT_WIDTH  = 1,
  parameter int unsigned COUNT_WIDTH   = 20,
  parameter int unsigned IMG_Y_WIDTH   = 10
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [IMG_Y_WIDTH-1:0]   param_height,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TNUMBER_WIDTH-1:0] m_frame_number,
  output logic [COUNT_WIDTH-1:0]   m_frame_count,
  output logic                     m_frame_valid,
  input  logic                     m_frame_ready,
  output logic                     err_short_frame
);

  localparam logic [TNUMBER_WIDTH-1:0] IgnoreIdx = TNUMBER_WIDTH'(IGNORE_CLASS);
  localparam logic [TNUMBER_WIDTH-1:0] LastIdx   = TNUMBER_WIDTH'(NUM_CLASS - 1);

  typedef enum logic [1:0] {StWaitSof, StAccum, StScan, StOutput} state_e;

  state_e                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   cnt_q [NUM_CLASS];
  logic [COUNT_WIDTH-1:0]   cnt_d [NUM_CLASS];
  logic [IMG_Y_WIDTH-1:0]   line_q, line_d, height_q, height_d;
  logic [TNUMBER_WIDTH-1:0] scan_idx_q, scan_idx_d, max_idx_q, max_idx_d, num_q, num_d;
  logic [COUNT_WIDTH-1:0]   max_q, max_d, count_q, count_d;
  logic                     err_q, err_d;

  logic                     accept, sof, count_beat, frame_end, vote_en;
  logic [IMG_Y_WIDTH-1:0]   cur_height, last_line, line_base;
  logic [31:0]              tnum_ext;
  logic [COUNT_WIDTH-1:0]   vote_base, scan_cnt;
  logic [COUNT_WIDTH:0]     vote_sum;

  assign s_axi4s_tready  = aresetn & ((state_q == StWaitSof) | (state_q == StAccum));
  assign m_frame_valid   = aresetn & (state_q == StOutput);
  assign m_frame_number  = num_q;
  assign m_frame_count   = count_q;
  assign err_short_frame = err_q;

  assign accept     = s_axi4s_tvalid & s_axi4s_tready;
  assign sof        = s_axi4s_tuser[0];
  assign count_beat = accept & (sof | (state_q == StAccum));
  // An SOF beat starts a fresh frame, so it sees the new height and a zero line count.
  assign cur_height = sof ? param_height : height_q;
  assign last_line  = (cur_height == '0) ? '0 : cur_height - 1'b1;
  assign line_base  = sof ? '0 : line_q;
  assign frame_end  = count_beat & s_axi4s_tlast & (line_base == last_line);
  assign tnum_ext   = 32'(s_axi4s_tnumber);
  assign vote_en    = count_beat & (tnum_ext < NUM_CLASS) & (tnum_ext != IGNORE_CLASS);
  assign scan_cnt   = cnt_q[scan_idx_q];

  always_comb begin
    vote_base = '0;
    vote_sum  = '0;
    for (int i = 0; i < int'(NUM_CLASS); i++) begin
      vote_base = (count_beat && sof) ? '0 : cnt_q[i];
      vote_sum  = {1'b0, vote_base} + (COUNT_WIDTH + 1)'(s_axi4s_tcount);
      if (vote_en && (tnum_ext == 32'(i))) begin
        cnt_d[i] = vote_sum[COUNT_WIDTH] ? '1 : vote_sum[COUNT_WIDTH-1:0];
      end else begin
        cnt_d[i] = vote_base;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    height_d   = height_q;
    scan_idx_d = scan_idx_q;
    max_d      = max_q;
    max_idx_d  = max_idx_q;
    num_d      = num_q;
    count_d    = count_q;
    err_d      = count_beat & sof & (state_q == StAccum);
    unique case (state_q)
      StWaitSof, StAccum: begin
        if (count_beat) begin
          if (sof) height_d = param_height;
          line_d     = line_base + IMG_Y_WIDTH'(s_axi4s_tlast);
          state_d    = frame_end ? StScan : StAccum;
          scan_idx_d = '0;
          max_d      = '0;
          max_idx_d  = IgnoreIdx;
        end
      end
      StScan: begin
        // Strictly-greater update keeps the lowest index on ties.
        if ((scan_idx_q != IgnoreIdx) && (scan_cnt > max_q)) begin
          max_d     = scan_cnt;
          max_idx_d = scan_idx_q;
        end
        scan_idx_d = scan_idx_q + 1'b1;
        if (scan_idx_q == LastIdx) begin
          state_d = StOutput;
          num_d   = (max_d == '0) ? IgnoreIdx : max_idx_d;
          count_d = max_d;
        end
      end
      StOutput: begin
        if (m_frame_ready) state_d = StWaitSof;
      end
      default: state_d = StWaitSof;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= StWaitSof;
      line_q     <= '0;
      height_q   <= '0;
      scan_idx_q <= '0;
      max_q      <= '0;
      max_idx_q  <= '0;
      num_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_CLASS); i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      height_q   <= height_d;
      scan_idx_q <= scan_idx_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      num_q      <= num_d;
      count_q    <= count_d;
      err_q      <= err_d;
      for (int i = 0; i < int'(NUM_CLASS); i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_video_dnn_frame_vote.sv
// Directed and randomized frames checked against a vote-tally model; a second instance with
// 3-bit counters covers saturation.
module tb_video_dnn_frame_vote;

  localparam int NC = 11;
  localparam int IGN = 10;

  logic        aclk, aresetn;
  logic [9:0]  param_height;
  logic [0:0]  s_axi4s_tuser;
  logic        s_axi4s_tlast, s_axi4s_tvalid, m_frame_ready;
  logic [3:0]  s_axi4s_tnumber;
  logic [0:0]  s_axi4s_tcount;
  logic        s_axi4s_tready, m_frame_valid, err_short_frame;
  logic [3:0]  m_frame_number;
  logic [19:0] m_frame_count;
  logic        sat_tready, sat_valid, sat_err;
  logic [3:0]  sat_number;
  logic [2:0]  sat_count;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_base = 0;
  int f_num[$];
  int f_cnt[$];
  int f_h, f_w;

  video_dnn_frame_vote dut (
    .aclk(aclk), .aresetn(aresetn), .param_height(param_height),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tnumber(s_axi4s_tnumber), .s_axi4s_tcount(s_axi4s_tcount),
    .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
    .m_frame_number(m_frame_number), .m_frame_count(m_frame_count),
    .m_frame_valid(m_frame_valid), .m_frame_ready(m_frame_ready),
    .err_short_frame(err_short_frame)
  );

  video_dnn_frame_vote #(.COUNT_WIDTH(3)) dut_sat (
    .aclk(aclk), .aresetn(aresetn), .param_height(param_height),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tnumber(s_axi4s_tnumber), .s_axi4s_tcount(s_axi4s_tcount),
    .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(sat_tready),
    .m_frame_number(sat_number), .m_frame_count(sat_count),
    .m_frame_valid(sat_valid), .m_frame_ready(m_frame_ready),
    .err_short_frame(sat_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(negedge aclk) if (err_short_frame === 1'b1) err_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Vote tally of the current frame; winner is the lowest class holding the strict maximum.
  function automatic void model(input int cw, output int num, output int cnt);
    int v[NC];
    int lim, best, bi;
    lim = (1 << cw) - 1;
    best = 0;
    bi = IGN;
    foreach (v[c]) v[c] = 0;
    for (int i = 0; i < f_num.size(); i++) begin
      if (f_num[i] < NC && f_num[i] != IGN) begin
        v[f_num[i]] += f_cnt[i];
        if (v[f_num[i]] > lim) v[f_num[i]] = lim;
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (c != IGN && v[c] > best) begin
        best = v[c];
        bi = c;
      end
    end
    num = bi;
    cnt = best;
  endfunction

  task automatic set_cnt(input int v);
    f_cnt.delete();
    foreach (f_num[i]) f_cnt.push_back(v);
  endtask

  task automatic build_random();
    int len;
    f_h = int'($urandom_range(0, 3));
    f_w = int'($urandom_range(2, 5));
    len = ((f_h == 0) ? 1 : f_h) * f_w;
    f_num.delete();
    f_cnt.delete();
    for (int i = 0; i < len; i++) begin
      f_num.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2))
                                                   : int'($urandom_range(0, 15)));
      f_cnt.push_back(int'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_beat(input logic u, input logic l, input int num, input int cnt);
    int n;
    n = 0;
    s_axi4s_tuser   = u;
    s_axi4s_tlast   = l;
    s_axi4s_tnumber = 4'(num);
    s_axi4s_tcount  = 1'(cnt);
    s_axi4s_tvalid  = 1'b1;
    while (s_axi4s_tready !== 1'b1 && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 200) chk("beat_accept_timeout", 32'(s_axi4s_tready), 1);
    @(posedge aclk); #1;
    s_axi4s_tvalid = 1'b0;
  endtask

  task automatic send_frame();
    int len;
    len = ((f_h == 0) ? 1 : f_h) * f_w;
    err_base = err_seen;
    param_height = 10'(f_h);
    for (int i = 0; i < len; i++) send_beat(i == 0, (i % f_w) == f_w - 1, f_num[i], f_cnt[i]);
  endtask

  task automatic wait_result(input string tag, input int en, input int ec, input int esn,
                             input int esc, input int eerr, input int hold, input int offer);
    int n, bad;
    logic [3:0] hn;
    logic [19:0] hc;
    n = 0;
    chk({tag, "_scan_tready"}, 32'(s_axi4s_tready), 0);
    while (m_frame_valid !== 1'b1 && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    chk({tag, "_latency"}, n + 1, NC + 1);
    chk({tag, "_number"}, 32'(m_frame_number), en);
    chk({tag, "_count"}, 32'(m_frame_count), ec);
    chk({tag, "_sat_number"}, 32'(sat_number), esn);
    chk({tag, "_sat_count"}, 32'(sat_count), esc);
    chk({tag, "_err_pulses"}, err_seen - err_base, eerr);
    if (hold > 0) begin
      if (offer != 0) begin
        s_axi4s_tuser = 1'b1; s_axi4s_tlast = 1'b0; param_height = 10'(f_h);
        s_axi4s_tnumber = 4'(f_num[0]); s_axi4s_tcount = 1'(f_cnt[0]); s_axi4s_tvalid = 1'b1;
      end
      bad = 0;
      hn = m_frame_number;
      hc = m_frame_count;
      repeat (hold) begin
        @(posedge aclk); #1;
        if (s_axi4s_tready !== 1'b0 || m_frame_valid !== 1'b1 ||
            m_frame_number !== hn || m_frame_count !== hc) bad++;
      end
      chk({tag, "_hold_stable"}, bad, 0);
    end
    m_frame_ready = 1'b1;
    @(posedge aclk); #1;
    m_frame_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(m_frame_valid), 0);
    chk({tag, "_tready_back"}, 32'(s_axi4s_tready), 1);
  endtask

  task automatic expect_no_result(input string tag);
    int vcnt;
    vcnt = 0;
    repeat (20) begin
      @(posedge aclk); #1;
      if (m_frame_valid !== 1'b0) vcnt++;
    end
    chk(tag, vcnt, 0);
  endtask

  initial begin
    int en, ec, esn, esc;
    aresetn = 1'b0; s_axi4s_tvalid = 1'b0; s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0;
    s_axi4s_tnumber = '0; s_axi4s_tcount = '0; m_frame_ready = 1'b0; param_height = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready", 32'(s_axi4s_tready), 0);
    chk("rst_valid", 32'(m_frame_valid), 0);
    chk("rst_number", 32'(m_frame_number), 0);
    chk("rst_count", 32'(m_frame_count), 0);
    chk("rst_err", 32'(err_short_frame), 0);
    aresetn = 1'b1;
    #1;
    chk("rst_release_tready", 32'(s_axi4s_tready), 1);

    // Beats before any SOF are dropped
    for (int i = 0; i < 6; i++) send_beat(1'b0, (i % 3) == 2, 3, 1);
    expect_no_result("no_sof_no_result");

    f_h = 2; f_w = 4; f_num = '{3, 3, 3, 5, 5, 1, 3, 7}; set_cnt(1);
    send_frame();
    wait_result("basic", 3, 4, 3, 4, 0, 0, 0);

    f_num = '{2, 2, 6, 6, 10, 10, 10, 10}; set_cnt(1);
    send_frame();
    wait_result("tie", 2, 2, 2, 2, 0, 0, 0);

    // Reset in the middle of a frame
    param_height = 10'd2;
    send_beat(1'b1, 1'b0, 2, 1);
    send_beat(1'b0, 1'b1, 2, 1);
    s_axi4s_tvalid = 1'b1; s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("midrst_tready", 32'(s_axi4s_tready), 0);
    chk("midrst_valid", 32'(m_frame_valid), 0);
    chk("midrst_number", 32'(m_frame_number), 0);
    chk("midrst_count", 32'(m_frame_count), 0);
    chk("midrst_err", 32'(err_short_frame), 0);
    s_axi4s_tvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    #1;
    chk("midrst_release_tready", 32'(s_axi4s_tready), 1);
    send_beat(1'b0, 1'b1, 2, 1);
    expect_no_result("midrst_no_result");

    f_h = 2; f_w = 4; f_num = '{10, 10, 4, 10, 7, 10, 12, 15};
    f_cnt = '{1, 1, 0, 1, 0, 1, 1, 1};
    send_frame();
    wait_result("no_votes", IGN, 0, IGN, 0, 0, 0, 0);

    // SOF after 3 beats of a 2-line frame, then a complete frame of class 4
    param_height = 10'd2;
    send_beat(1'b1, 1'b0, 9, 1);
    send_beat(1'b0, 1'b0, 9, 1);
    send_beat(1'b0, 1'b0, 9, 1);
    f_h = 2; f_w = 4; f_num = '{4, 4, 4, 4, 4, 4, 4, 4}; set_cnt(1);
    send_frame();
    wait_result("midsof", 4, 8, 4, 7, 1, 0, 0);

    f_h = 2; f_w = 5; f_num = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}; set_cnt(1);
    send_frame();
    wait_result("saturate", 0, 10, 0, 7, 0, 0, 0);

    // Result held for 20 cycles while the next frame is offered
    f_h = 2; f_w = 4; f_num = '{5, 5, 5, 1, 5, 5, 1, 5}; set_cnt(1);
    send_frame();
    build_random();
    wait_result("backpressure", 5, 6, 5, 6, 0, 20, 1);
    model(20, en, ec);
    model(3, esn, esc);
    send_frame();
    wait_result("after_bp", en, ec, esn, esc, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      build_random();
      model(20, en, ec);
      model(3, esn, esc);
      send_frame();
      wait_result($sformatf("rand%0d", k), en, ec, esn, esc, 0, int'($urandom_range(0, 3)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_dnn_frame_vote.md
# video_dnn_frame_vote

Frame-level vote accumulator that consumes the per-pixel classification stream produced by the MNIST segmentation/classification pipeline (tnumber/tcount from the max-count stage). It counts weighted votes per class over one video frame. At end of frame it scans the counters and emits a single-beat result: the winning class and its vote count. It sits at the receiving end of the classification stream and feeds the register/overlay logic with one decision per frame.

## Interface

- NUM_CLASS, 11, number of classes; valid tnumber range 0..NUM_CLASS-1
- IGNORE_CLASS, 10, class excluded from voting (the "not a digit" class); also reported when a frame has no votes
- TUSER_WIDTH, 1, tuser width; only bit 0 (SOF) is used
- TNUMBER_WIDTH, 4, class index width
- TCOUNT_WIDTH, 1, per-pixel vote weight width
- COUNT_WIDTH, 20, per-class vote counter width
- IMG_Y_WIDTH, 10, width of the line-count parameter

- aclk  in  1  clock
- aresetn  in  1  synchronous, active-low reset
- param_height  in  IMG_Y_WIDTH  lines per frame; sampled on the accepted SOF beat
- s_axi4s_tuser  in  TUSER_WIDTH  bit 0 = start of frame
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tnumber  in  TNUMBER_WIDTH  pixel class
- s_axi4s_tcount  in  TCOUNT_WIDTH  pixel vote weight
- s_axi4s_tvalid  in  1  beat valid
- s_axi4s_tready  out  1  beat accepted when tvalid & tready
- m_frame_number  out  TNUMBER_WIDTH  winning class
- m_frame_count  out  COUNT_WIDTH  vote count of the winner
- m_frame_valid  out  1  result valid
- m_frame_ready  in  1  result accepted when valid & ready
- err_short_frame  out  1  one-cycle pulse: SOF arrived before the frame completed

## Operation

- States: WAIT_SOF, ACCUM, SCAN, OUTPUT.
- s_axi4s_tready = 1 in WAIT_SOF and ACCUM, 0 in SCAN and OUTPUT. It is decoded combinationally from the registered state and is 0 while aresetn = 0.
- WAIT_SOF:
  - Accepted beats with tuser[0] = 0 are discarded.
  - An accepted beat with tuser[0] = 1 clears all counters and the line counter, latches param_height, counts the beat, and moves to ACCUM.
- Vote rule, applied to every counted beat: add tcount to counter[tnumber] only if tnumber < NUM_CLASS and tnumber != IGNORE_CLASS. Other tnumber values are ignored. Counters saturate at 2^COUNT_WIDTH-1.
- ACCUM:
  - Each accepted beat is counted.
  - An accepted tlast increments the line counter.
  - An accepted beat with tlast = 1 while the line counter = latched height-1 ends the frame and moves to SCAN.
  - A latched height of 0 is treated as 1.
- ACCUM, SOF arrives mid-frame (accepted tuser[0] = 1):
  - err_short_frame pulses for 1 cycle.
  - Counters and line counter are cleared, height is re-latched, and the beat is counted as the first beat of the new frame.
  - The state stays ACCUM.
  - If that same beat also completes the frame, the frame end takes effect as well.
- SCAN:
  - One class per cycle, index 0..NUM_CLASS-1.
  - A running max is updated only on strictly greater, so ties resolve to the lowest index.
  - The ignore class is skipped, but it still takes one cycle.
  - After NUM_CLASS cycles, go to OUTPUT.
  - If max = 0: number = IGNORE_CLASS, count = 0.
- OUTPUT:
  - m_frame_valid = 1; number and count are held stable until m_frame_ready.
  - On handshake go to WAIT_SOF.
  - Input beats arriving meanwhile are back-pressured, not dropped.
- Reset (aresetn = 0 at a clock edge): state WAIT_SOF, all counters 0, m_frame_valid 0, m_frame_number 0, m_frame_count 0, err_short_frame 0. This applies from any state, including mid-frame and mid-OUTPUT; a pending result is discarded.

## Timing

- Throughput in ACCUM: 1 beat/cycle.
- Counter update is registered: a beat accepted in cycle T is visible in the counters at T+1.
- Last beat of a frame accepted in cycle T:
  - SCAN occupies T+1..T+NUM_CLASS.
  - m_frame_valid rises at T+NUM_CLASS+1.
  - Latency is NUM_CLASS+1 cycles.
- Result handshake in cycle H: m_frame_valid = 0 and s_axi4s_tready = 1 at H+1.
- Handshake with m_frame_ready held high: valid lasts exactly 1 cycle.
- err_short_frame is asserted in the cycle after the offending SOF is accepted.
- Minimum frame-to-frame dead time: NUM_CLASS+1 cycles of tready = 0.

## Test plan

- Frame with param_height = 2, 4 px/line, all tcount = 1, tnumber = 3,3,3,5,5,1,3,7 -> one result: number 3, count 4. m_frame_valid rises 12 cycles after the last beat is accepted.
- Tie: same frame with tnumber = 2,2,6,6 then 10×4 -> number 2, count 2. The IGNORE_CLASS pixels are not counted.
- All pixels tnumber = 10 or tcount = 0 -> number 10, count 0.
- SOF injected after 3 beats of a 2-line frame, then a full 8-beat frame of class 4 -> err_short_frame pulses once; result number 4, count 8.
- m_frame_ready held 0 for 20 cycles while the next frame is offered:
  - tready stays 0 and the result is stable throughout.
  - After ready, the next frame is accepted intact and produces its own correct result.
- Leading beats before any SOF:
  - Beats without SOF are discarded and produce no result.
  - aresetn pulled low mid-ACCUM gives all outputs 0 and tready 0 during reset, then WAIT_SOF.
  - Counter saturation with COUNT_WIDTH = 3: 10 votes of class 0 -> count 7.
